// File: rtl/intr_vec_pkg.sv
// Shared constants for the vectored interrupt controller: register map,
// CTRL bit positions and the request FSM state encoding.
package intr_vec_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_IE     = 3'd1;
   localparam logic [2:0] ADDR_MODE   = 3'd2;
   localparam logic [2:0] ADDR_PEND   = 3'd3;
   localparam logic [2:0] ADDR_ISR    = 3'd4;
   localparam logic [2:0] ADDR_DEPTH  = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;

   localparam int CTRL_GIE       = 15;
   localparam int CTRL_ERR_UNDER = 0;
   localparam int CTRL_ERR_COLL  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_e;

endpackage

// File: rtl/intr_pc_lifo.sv
// Hardware PC-save stack: one entry pushed per accepted interrupt, one popped
// per accepted end-of-interrupt. Overflow and underflow requests are ignored.
module intr_pc_lifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 push_data,
   output logic [W-1:0]                 top_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [CW-1:0] count_r;
   logic [AW-1:0] wr_idx_s;
   logic [AW-1:0] rd_idx_s;

   assign wr_idx_s = AW'(count_r);
   assign rd_idx_s = AW'(count_r - CW'(1));
   assign full     = (count_r == CW'(DEPTH));
   assign empty    = (count_r == CW'(0));
   assign count    = count_r;
   assign top_data = mem_r[rd_idx_s];

   // Stack storage and occupancy counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= CW'(0);
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (push && !full) begin
         mem_r[wr_idx_s] <= push_data;
         count_r         <= count_r + CW'(1);
      end else if (pop && !empty) begin
         count_r <= count_r - CW'(1);
      end
   end

endmodule

// File: rtl/intr_vec_ctrl.sv
// Vectored interrupt controller: N prioritised sources with enable and
// edge/level mode, nested preemption and a PC-save stack for the core FSM.
module intr_vec_ctrl
   import intr_vec_pkg::*;
#(
   parameter int              N_SRC       = 8,
   parameter int              PC_W        = 8,
   parameter int              NEST_DEPTH  = 4,
   parameter logic [PC_W-1:0] VEC_BASE    = PC_W'(8'h10),
   parameter int              VEC_STRIDE  = 4,
   parameter int              SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] src_in,
   input  logic             reg_we,
   input  logic [2:0]       reg_addr,
   input  logic [15:0]      reg_wdata,
   output logic [15:0]      reg_rdata,
   output logic             irq_req,
   output logic [PC_W-1:0]  irq_vec,
   output logic [3:0]       irq_id,
   input  logic             irq_ack,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             eoi,
   output logic [PC_W-1:0]  ret_pc,
   output logic             ret_valid
);

   localparam int CW = $clog2(NEST_DEPTH + 1);

   logic [N_SRC-1:0] sync_r [SYNC_STAGES];
   logic [N_SRC-1:0] prev_r, lvl_s, rise_s;
   logic             gie_r, err_under_r, err_coll_r;
   logic [N_SRC-1:0] ie_r, mode_r, pend_r, isr_r;
   state_e           state_r;
   logic             req_r, ret_valid_r;
   logic [3:0]       id_r, win_s;
   logic [PC_W-1:0]  vec_r, vec_s, ret_pc_r, lifo_top_s;
   logic             lifo_full_s, lifo_empty_s, any_s;
   logic [CW-1:0]    lifo_count_s;
   logic             ack_acc_s, eoi_ok_s;
   logic             wr_ctrl_s, wr_ie_s, wr_mode_s, wr_pend_s;
   logic [N_SRC-1:0] isr_low_s, below_s, elig_s, ack_mask_s;
   logic [N_SRC-1:0] pend_clr_s, pend_nxt_s, isr_nxt_s;
   logic             wdata_unused_s;

   assign wdata_unused_s = ^reg_wdata;

   // Input synchroniser chain plus previous-level flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= {N_SRC{1'b0}};
         end
         prev_r <= {N_SRC{1'b0}};
      end else begin
         sync_r[0] <= src_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         prev_r <= lvl_s;
      end
   end

   assign lvl_s  = sync_r[SYNC_STAGES-1];
   assign rise_s = lvl_s & ~prev_r;

   assign wr_ctrl_s = reg_we && (reg_addr == ADDR_CTRL);
   assign wr_ie_s   = reg_we && (reg_addr == ADDR_IE);
   assign wr_mode_s = reg_we && (reg_addr == ADDR_MODE);
   assign wr_pend_s = reg_we && (reg_addr == ADDR_PEND);

   assign ack_acc_s = irq_ack && (state_r == REQ);
   assign eoi_ok_s  = eoi && !ack_acc_s && !lifo_empty_s;

   // Lowest set ISR bit is the active level; only strictly lower indices may
   // preempt. With ISR=0 the subtraction wraps to all ones.
   assign isr_low_s = isr_r & (~isr_r + N_SRC'(1'b1));
   assign below_s   = isr_low_s - N_SRC'(1'b1);
   assign elig_s    = (gie_r && !lifo_full_s) ? (ie_r & pend_r & ~isr_r & below_s)
                                              : {N_SRC{1'b0}};

   // Priority encoder: lowest eligible index wins.
   always_comb begin
      win_s = 4'd0;
      any_s = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         win_s = elig_s[i] ? 4'(i) : win_s;
         any_s = any_s | elig_s[i];
      end
   end

   assign vec_s      = VEC_BASE + PC_W'(int'(win_s) * VEC_STRIDE);
   assign ack_mask_s = ack_acc_s ? ({{(N_SRC-1){1'b0}}, 1'b1} << id_r) : {N_SRC{1'b0}};

   // Edge bits: set beats clear. Level bits simply track the synchronised line.
   assign pend_clr_s = mode_r & ((wr_pend_s ? reg_wdata[N_SRC-1:0] : {N_SRC{1'b0}}) | ack_mask_s);
   assign pend_nxt_s = (mode_r & ((pend_r & ~pend_clr_s) | rise_s)) | (~mode_r & lvl_s);
   assign isr_nxt_s  = (isr_r & ~(eoi_ok_s ? isr_low_s : {N_SRC{1'b0}})) | ack_mask_s;

   // Configuration, pending, in-service, error and return registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gie_r       <= 1'b0;
         err_under_r <= 1'b0;
         err_coll_r  <= 1'b0;
         ie_r        <= {N_SRC{1'b0}};
         mode_r      <= {N_SRC{1'b0}};
         pend_r      <= {N_SRC{1'b0}};
         isr_r       <= {N_SRC{1'b0}};
         ret_valid_r <= 1'b0;
         ret_pc_r    <= {PC_W{1'b0}};
      end else begin
         if (wr_ctrl_s) gie_r <= reg_wdata[CTRL_GIE];
         if (wr_ie_s)   ie_r  <= reg_wdata[N_SRC-1:0];
         if (wr_mode_s) mode_r <= reg_wdata[N_SRC-1:0];
         err_under_r <= (err_under_r & ~(wr_ctrl_s & reg_wdata[CTRL_ERR_UNDER]))
                        | (eoi && !ack_acc_s && lifo_empty_s);
         err_coll_r  <= (err_coll_r & ~(wr_ctrl_s & reg_wdata[CTRL_ERR_COLL]))
                        | (eoi && ack_acc_s);
         pend_r      <= pend_nxt_s;
         isr_r       <= isr_nxt_s;
         ret_valid_r <= eoi_ok_s;
         if (eoi_ok_s) ret_pc_r <= lifo_top_s;
      end
   end

   // Request FSM; winner and vector are tracked every cycle while in REQ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         req_r   <= 1'b0;
         id_r    <= 4'd0;
         vec_r   <= {PC_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (any_s) begin
                  state_r <= REQ;
                  req_r   <= 1'b1;
                  id_r    <= win_s;
                  vec_r   <= vec_s;
               end
            end
            REQ: begin
               if (ack_acc_s) begin
                  state_r <= GAP;
                  req_r   <= 1'b0;
               end else if (any_s) begin
                  id_r  <= win_s;
                  vec_r <= vec_s;
               end else begin
                  state_r <= IDLE;
                  req_r   <= 1'b0;
               end
            end
            GAP: begin
               state_r <= IDLE;
               req_r   <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               req_r   <= 1'b0;
            end
         endcase
      end
   end

   intr_pc_lifo #(
      .W     (PC_W),
      .DEPTH (NEST_DEPTH)
   ) u_lifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ack_acc_s),
      .pop       (eoi_ok_s),
      .push_data (pc_in),
      .top_data  (lifo_top_s),
      .full      (lifo_full_s),
      .empty     (lifo_empty_s),
      .count     (lifo_count_s)
   );

   // Register read mux.
   always_comb begin
      reg_rdata = 16'h0000;
      case (reg_addr)
         ADDR_CTRL: begin
            reg_rdata[CTRL_GIE]       = gie_r;
            reg_rdata[CTRL_ERR_UNDER] = err_under_r;
            reg_rdata[CTRL_ERR_COLL]  = err_coll_r;
         end
         ADDR_IE:    reg_rdata = 16'(ie_r);
         ADDR_MODE:  reg_rdata = 16'(mode_r);
         ADDR_PEND:  reg_rdata = 16'(pend_r);
         ADDR_ISR:   reg_rdata = 16'(isr_r);
         ADDR_DEPTH: reg_rdata = 16'(lifo_count_s);
         ADDR_STATUS: begin
            reg_rdata[15]  = req_r;
            reg_rdata[3:0] = id_r;
         end
         default:    reg_rdata = 16'h0000;
      endcase
   end

   assign irq_req   = req_r;
   assign irq_vec   = vec_r;
   assign irq_id    = id_r;
   assign ret_pc    = ret_pc_r;
   assign ret_valid = ret_valid_r;

endmodule

// File: tb/tb_intr_vec_ctrl.sv
// Directed walk through the controller's behaviour followed by a randomised
// phase scored against a transaction-level model (pending set, ISR, PC stack).
module tb_intr_vec_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  src_in;
   logic        reg_we;
   logic [2:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata;
   logic        irq_req;
   logic [7:0]  irq_vec;
   logic [3:0]  irq_id;
   logic        irq_ack;
   logic [7:0]  pc_in;
   logic        eoi;
   logic [7:0]  ret_pc;
   logic        ret_valid;

   int n_cmp;
   int n_mis;

   logic [7:0] m_pend;
   logic [7:0] m_isr;
   logic [7:0] m_stack[$];
   logic       m_under;

   intr_vec_ctrl #(
      .N_SRC(8), .PC_W(8), .NEST_DEPTH(2), .VEC_BASE(8'h10), .VEC_STRIDE(4), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .src_in(src_in), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq_req(irq_req), .irq_vec(irq_vec),
      .irq_id(irq_id), .irq_ack(irq_ack), .pc_in(pc_in), .eoi(eoi), .ret_pc(ret_pc),
      .ret_valid(ret_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      step();
      reg_we = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
      reg_addr = a;
      #1;
      chk(tag, 32'(reg_rdata), 32'(exp));
   endtask

   task automatic ack_pc(input logic [7:0] pc);
      irq_ack = 1'b1; pc_in = pc;
      step();
      irq_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1;
      step();
      eoi = 1'b0;
   endtask

   // Reference winner: lowest pending index below the active level, stack not full.
   function automatic int m_win();
      int low = 8;
      for (int i = 7; i >= 0; i--) if (m_isr[i]) low = i;
      if (m_stack.size() >= 2) return -1;
      for (int i = 0; i < low; i++) if (m_pend[i]) return i;
      return -1;
   endfunction

   task automatic check_model(input int it);
      int w;
      w = m_win();
      chk($sformatf("rnd%0d.req", it), 32'(irq_req), (w >= 0) ? 32'h1 : 32'h0);
      if (w >= 0) begin
         chk($sformatf("rnd%0d.id", it), 32'(irq_id), 32'(w));
         chk($sformatf("rnd%0d.vec", it), 32'(irq_vec), 32'(16 + 4 * w));
      end
      rd_chk($sformatf("rnd%0d.pend", it), 3'd3, 16'(m_pend));
      rd_chk($sformatf("rnd%0d.isr", it), 3'd4, 16'(m_isr));
      rd_chk($sformatf("rnd%0d.depth", it), 3'd5, 16'(m_stack.size()));
      rd_chk($sformatf("rnd%0d.ctrl", it), 3'd0, 16'h8000 | 16'(m_under));
   endtask

   initial begin
      int act, s, w;
      logic [7:0] pc, exp_pc;
      bit done;

      n_cmp = 0; n_mis = 0;
      rst_n = 1'b0; src_in = 8'h00; reg_we = 1'b0; reg_addr = 3'd0; reg_wdata = 16'h0000;
      irq_ack = 1'b0; pc_in = 8'h00; eoi = 1'b0;
      step(2);
      chk("rst.req", 32'(irq_req), 32'h0);
      chk("rst.vec", 32'(irq_vec), 32'h0);
      chk("rst.retv", 32'(ret_valid), 32'h0);
      rd_chk("rst.ctrl", 3'd0, 16'h0000);
      rd_chk("rst.depth", 3'd5, 16'h0000);
      rst_n = 1'b1;
      step();

      // Single edge source served and returned
      wr(3'd1, 16'h0003); wr(3'd2, 16'h0003); wr(3'd0, 16'h8000);
      src_in[1] = 1'b1;
      step(2);
      rd_chk("t1.pend_early", 3'd3, 16'h0000);
      step();
      rd_chk("t1.pend", 3'd3, 16'h0002);
      chk("t1.req_early", 32'(irq_req), 32'h0);
      step();
      chk("t1.req", 32'(irq_req), 32'h1);
      chk("t1.id", 32'(irq_id), 32'h1);
      chk("t1.vec", 32'(irq_vec), 32'h14);
      src_in[1] = 1'b0;
      ack_pc(8'h23);
      chk("t2.gap", 32'(irq_req), 32'h0);
      rd_chk("t2.isr", 3'd4, 16'h0002);
      rd_chk("t2.depth", 3'd5, 16'h0001);
      rd_chk("t2.pend", 3'd3, 16'h0000);
      step();
      chk("t2.idle", 32'(irq_req), 32'h0);
      pulse_eoi();
      chk("t2.retv", 32'(ret_valid), 32'h1);
      chk("t2.retpc", 32'(ret_pc), 32'h23);
      rd_chk("t2.isr0", 3'd4, 16'h0000);
      rd_chk("t2.depth0", 3'd5, 16'h0000);
      step();
      chk("t2.retv_off", 32'(ret_valid), 32'h0);

      // Nesting and stack-full blocking
      wr(3'd1, 16'h0007); wr(3'd2, 16'h0007);
      src_in[2] = 1'b1; step(4); src_in[2] = 1'b0;
      chk("t3.req2", 32'(irq_req), 32'h1);
      chk("t3.vec2", 32'(irq_vec), 32'h18);
      ack_pc(8'h40); step(2);
      src_in[0] = 1'b1; step(4); src_in[0] = 1'b0;
      chk("t3.id0", 32'(irq_id), 32'h0);
      chk("t3.vec0", 32'(irq_vec), 32'h10);
      ack_pc(8'h30); step(2);
      rd_chk("t3.isr", 3'd4, 16'h0005);
      src_in[1] = 1'b1; step(4); src_in[1] = 1'b0; step(2);
      chk("t3.blocked", 32'(irq_req), 32'h0);
      rd_chk("t3.pend1", 3'd3, 16'h0002);
      pulse_eoi();
      chk("t3.retpc", 32'(ret_pc), 32'h30);
      chk("t3.req_k", 32'(irq_req), 32'h0);
      rd_chk("t3.isr4", 3'd4, 16'h0004);
      step();
      chk("t3.req1", 32'(irq_req), 32'h1);
      chk("t3.id1", 32'(irq_id), 32'h1);
      ack_pc(8'h50); step(2);
      rd_chk("t4.full", 3'd5, 16'h0002);
      src_in[0] = 1'b1; step(4); src_in[0] = 1'b0; step(2);
      chk("t4.noreq", 32'(irq_req), 32'h0);
      rd_chk("t4.held", 3'd3, 16'h0001);
      pulse_eoi();
      chk("t4.retpc", 32'(ret_pc), 32'h50);
      chk("t4.req_k", 32'(irq_req), 32'h0);
      step();
      chk("t4.req", 32'(irq_req), 32'h1);
      chk("t4.id", 32'(irq_id), 32'h0);
      ack_pc(8'h60); step(2);
      pulse_eoi();
      chk("t4.ret60", 32'(ret_pc), 32'h60);
      step();
      pulse_eoi();
      chk("t4.ret40", 32'(ret_pc), 32'h40);
      rd_chk("t4.isr0", 3'd4, 16'h0000);
      rd_chk("t4.depth0", 3'd5, 16'h0000);

      // Set/clear collision, underflow and ack/eoi collision
      wr(3'd1, 16'h000F); wr(3'd2, 16'h000F);
      src_in[3] = 1'b1; step(2);
      reg_we = 1'b1; reg_addr = 3'd3; reg_wdata = 16'h0008;
      step();
      reg_we = 1'b0; src_in[3] = 1'b0;
      rd_chk("t5.setwins", 3'd3, 16'h0008);
      pulse_eoi();
      chk("t5.noretv", 32'(ret_valid), 32'h0);
      rd_chk("t5.under", 3'd0, 16'h8001);
      chk("t5.req3", 32'(irq_id), 32'h3);
      irq_ack = 1'b1; eoi = 1'b1; pc_in = 8'h77;
      step();
      irq_ack = 1'b0; eoi = 1'b0;
      rd_chk("t5.coll", 3'd0, 16'h8003);
      rd_chk("t5.depth", 3'd5, 16'h0001);
      rd_chk("t5.isr", 3'd4, 16'h0008);
      step();
      chk("t5.retv", 32'(ret_valid), 32'h0);
      wr(3'd0, 16'h8003);
      rd_chk("t5.w1c", 3'd0, 16'h8000);
      wr(3'd0, 16'h0000);
      src_in[2] = 1'b1; step(4); src_in[2] = 1'b0; step(2);
      chk("t5.gie_off", 32'(irq_req), 32'h0);
      rd_chk("t5.pend4", 3'd3, 16'h0004);
      wr(3'd3, 16'h0004);
      rd_chk("t5.pend_w1c", 3'd3, 16'h0000);
      wr(3'd0, 16'h8000);

      // Asynchronous reset in the middle of a request
      src_in[1] = 1'b1; step(4); src_in[1] = 1'b0;
      chk("t6.req", 32'(irq_req), 32'h1);
      rd_chk("t6.depth", 3'd5, 16'h0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.req0", 32'(irq_req), 32'h0);
      chk("t6.vec0", 32'(irq_vec), 32'h0);
      chk("t6.retv0", 32'(ret_valid), 32'h0);
      chk("t6.rdata0", 32'(reg_rdata), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      for (int a = 0; a < 8; a++) rd_chk($sformatf("t6.reg%0d", a), 3'(a), 16'h0000);

      // Randomised phase against the transaction-level model
      m_pend = 8'h00; m_isr = 8'h00; m_under = 1'b0; m_stack.delete();
      step();
      wr(3'd1, 16'h00FF); wr(3'd2, 16'h00FF); wr(3'd0, 16'h8000);
      for (int it = 0; it < 80; it++) begin
         act = $urandom_range(0, 2);
         if (act == 0) begin
            s = $urandom_range(0, 7);
            src_in[s] = 1'b1; step(2); src_in[s] = 1'b0; step(4);
            m_pend[s] = 1'b1;
         end else if (act == 1) begin
            w = m_win();
            pc = 8'($urandom);
            ack_pc(pc);
            if (w >= 0) begin
               chk($sformatf("rnd%0d.gap", it), 32'(irq_req), 32'h0);
               m_stack.push_back(pc);
               m_isr[w] = 1'b1;
               m_pend[w] = 1'b0;
            end
            step(3);
         end else begin
            pulse_eoi();
            if (m_stack.size() == 0) begin
               m_under = 1'b1;
               chk($sformatf("rnd%0d.noretv", it), 32'(ret_valid), 32'h0);
            end else begin
               exp_pc = m_stack.pop_back();
               done = 1'b0;
               for (int i = 0; i < 8; i++) begin
                  if (m_isr[i] && !done) begin
                     m_isr[i] = 1'b0;
                     done = 1'b1;
                  end
               end
               chk($sformatf("rnd%0d.retv", it), 32'(ret_valid), 32'h1);
               chk($sformatf("rnd%0d.retpc", it), 32'(ret_pc), 32'(exp_pc));
            end
            step(2);
         end
         check_model(it);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
